// File: rtl/pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl
//
// Fetch sequencer. It owns the architectural PC, issues one instruction-memory
// request at a time, and hands each fetched instruction, tagged with its PC,
// to decode over a valid/ready handshake. The next PC comes from one of three
// sources, highest priority first: trap redirect, execute redirect, and the
// sequential pc+4.
//
// Optional feature macro: FETCH_MISALIGN_EN
//   When it is defined, a redirect whose target is not 4-byte aligned raises a
//   sticky misalign_err and does not load the PC. The flag also blocks new
//   fetches until a trap arrives with an aligned target.
//   When it is undefined, misalign_err is tied to 0 and targets load without
//   any check.
//
// Parameters:
//   XLEN      address/instruction width (only 32 is supported)
//   RESET_PC  PC value loaded by reset
//
// Ports:
//   clk, rstn                   clock, asynchronous active-low reset
//   imem_req_valid/ready/addr   fetch request channel to imem
//   imem_rsp_valid/data         imem response (one pulse per accepted request)
//   inst_valid/ready, inst      instruction channel to decode
//   inst_pc                     PC of the instruction currently on inst
//   redirect_valid/pc           execute-stage control-flow change
//   trap_valid/pc               trap/mret redirect from the CSR unit
//   pc                          current fetch PC
//   misalign_err                sticky misaligned-target flag
// ---------------------------------------------------------------------------
module pc_fetch_ctrl #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rstn,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  output logic [XLEN-1:0] pc,
  output logic            misalign_err
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,  // presenting a request to imem
    S_WAIT  = 2'd1,  // request accepted, waiting for its response
    S_OUT   = 2'd2,  // instruction held for decode
    S_DRAIN = 2'd3   // discarding the response of an abandoned request
  } state_t;

  localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

  state_t          state_r;
  state_t          state_nxt_s;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] inst_r;
  logic [XLEN-1:0] inst_pc_r;
  logic            inst_valid_r;
  logic            misalign_r;

  logic            redir_s;
  logic [XLEN-1:0] target_s;
  logic            target_ok_s;
  logic            req_valid_s;
  logic            req_hs_s;
  logic            consume_s;
  logic            capture_s;

  // Redirect source selection: a trap always overrides an execute redirect.
  always_comb begin
    redir_s = trap_valid | redirect_valid;
    if (trap_valid) begin
      target_s = trap_pc;
    end else begin
      target_s = redirect_pc;
    end
  end

`ifdef FETCH_MISALIGN_EN
  assign target_ok_s = (target_s[1:0] == 2'b00);

  // Sticky misalignment flag; only an aligned trap target clears it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      misalign_r <= 1'b0;
    end else if (redir_s && !target_ok_s) begin
      misalign_r <= 1'b1;
    end else if (trap_valid && target_ok_s) begin
      misalign_r <= 1'b0;
    end else begin
      misalign_r <= misalign_r;
    end
  end
`else
  assign target_ok_s = 1'b1;
  assign misalign_r  = 1'b0;
`endif

  // Output decode from registered state; a pending misalignment blocks fetch.
  always_comb begin
    req_valid_s = (state_r == S_REQ) && !misalign_r;
  end

  assign req_hs_s  = req_valid_s & imem_req_ready;
  assign consume_s = (state_r == S_OUT) & inst_ready;
  // A redirect in the same cycle as the response makes the data stale.
  assign capture_s = (state_r == S_WAIT) & imem_rsp_valid & ~redir_s;

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= S_REQ;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic. A redirect abandons the current fetch. If a
  // request is already in flight, its response must still be drained.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_REQ: begin
        if (req_hs_s) begin
          if (redir_s) begin
            state_nxt_s = S_DRAIN;
          end else begin
            state_nxt_s = S_WAIT;
          end
        end else begin
          state_nxt_s = S_REQ;
        end
      end
      S_WAIT: begin
        if (redir_s) begin
          if (imem_rsp_valid) begin
            state_nxt_s = S_REQ;
          end else begin
            state_nxt_s = S_DRAIN;
          end
        end else if (imem_rsp_valid) begin
          state_nxt_s = S_OUT;
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      S_OUT: begin
        if (redir_s || inst_ready) begin
          state_nxt_s = S_REQ;
        end else begin
          state_nxt_s = S_OUT;
        end
      end
      S_DRAIN: begin
        if (imem_rsp_valid) begin
          state_nxt_s = S_REQ;
        end else begin
          state_nxt_s = S_DRAIN;
        end
      end
      default: begin
        state_nxt_s = S_REQ;
      end
    endcase
  end

  // PC update. A redirect wins over a same-cycle consume, so no +4 is applied.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_r <= RESET_PC;
    end else if (redir_s) begin
      if (target_ok_s) begin
        pc_r <= target_s;
      end else begin
        pc_r <= pc_r;
      end
    end else if (consume_s) begin
      pc_r <= pc_r + PC_STEP;
    end else begin
      pc_r <= pc_r;
    end
  end

  // Instruction word and tag capture on an accepted response.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inst_r    <= {XLEN{1'b0}};
      inst_pc_r <= {XLEN{1'b0}};
    end else if (capture_s) begin
      inst_r    <= imem_rsp_data;
      inst_pc_r <= pc_r;
    end else begin
      inst_r    <= inst_r;
      inst_pc_r <= inst_pc_r;
    end
  end

  // Decode-side valid: set on capture, cleared on consume or any redirect.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inst_valid_r <= 1'b0;
    end else if (redir_s) begin
      inst_valid_r <= 1'b0;
    end else if (capture_s) begin
      inst_valid_r <= 1'b1;
    end else if (consume_s) begin
      inst_valid_r <= 1'b0;
    end else begin
      inst_valid_r <= inst_valid_r;
    end
  end

  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = pc_r;
  assign inst_valid     = inst_valid_r;
  assign inst           = inst_r;
  assign inst_pc        = inst_pc_r;
  assign pc             = pc_r;
  assign misalign_err   = misalign_r;

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Fetch sequencer that owns the architectural PC and issues instruction-memory requests.
- Delivers fetched instructions, tagged with their PC, to decode over a valid/ready handshake.
- Selects the next PC from three sources, highest priority first: trap redirect, execute redirect (branch/jal/jalr), sequential pc+4.
- Sits between imem and the decode stage; replaces the free-running PC incrementer.

Parameters:
- RESET_PC, 32'h8000_0000, PC loaded by reset.
- XLEN, 32, address/instruction width; only 32 is supported.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rstn  input  1  reset, asynchronous, active-low.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  imem accepts request.
- imem_req_addr  output  XLEN  fetch address.
- imem_rsp_valid  input  1  instruction data valid (one pulse per accepted request).
- imem_rsp_data  input  XLEN  instruction word.
- inst_valid  output  1  instruction available to decode.
- inst_ready  input  1  decode consumes instruction.
- inst  output  XLEN  instruction word.
- inst_pc  output  XLEN  PC of inst.
- redirect_valid  input  1  execute-stage control-flow change.
- redirect_pc  input  XLEN  execute target.
- trap_valid  input  1  trap/mret redirect from CSR unit.
- trap_pc  input  XLEN  trap target (mtvec/mepc).
- pc  output  XLEN  current fetch PC.
- misalign_err  output  1  misaligned-target flag (FETCH_MISALIGN_EN only; otherwise tied 0).

Behaviour:
- Reset (rstn=0, asynchronous):
  - pc=RESET_PC, state=S_REQ.
  - inst_valid=0, inst=0, inst_pc=0, misalign_err=0.
- Outputs:
  - imem_req_valid = (state==S_REQ), registered-state decode, asserted in the first cycle after reset release.
  - imem_req_addr = pc.
- States S_REQ, S_WAIT, S_OUT, S_DRAIN. Without a redirect:
  - S_REQ: hold valid; addr stays stable until imem_req_ready; on handshake go to S_WAIT.
  - S_WAIT: on imem_rsp_valid latch inst<=imem_rsp_data and inst_pc<=pc, set inst_valid=1, go to S_OUT.
  - S_OUT: hold inst, inst_pc, inst_valid stable; on inst_ready clear inst_valid, set pc<=pc+4, go to S_REQ.
  - S_DRAIN: wait for the single outstanding imem_rsp_valid, discard the data, go to S_REQ. inst_valid stays 0.
- Redirect handling:
  - Redirect = trap_valid | redirect_valid; target = trap_valid ? trap_pc : redirect_pc.
  - Every redirect sets pc<=target and clears inst_valid on the same edge.
  - Next state per current state:
    - S_REQ, no handshake this cycle: S_REQ. The new addr is presented next cycle; changing addr while valid and not ready is legal only on a redirect.
    - S_REQ with handshake this cycle: S_DRAIN, because the old address was accepted.
    - S_WAIT without rsp_valid: S_DRAIN.
    - S_WAIT with rsp_valid: the response is discarded; go to S_REQ.
    - S_OUT, including when inst_ready is high in the same cycle: S_REQ. The redirect wins; no +4 is applied.
    - S_DRAIN: stay in S_DRAIN, or go to S_REQ if rsp_valid is high this cycle. The latest target overwrites pc.
- Arithmetic:
  - pc+4 is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0.
  - Targets are used as given; no bits are masked.
- Throughput: zero-wait imem (ready=1, rsp one cycle after handshake) and inst_ready=1 give one instruction per 3 cycles.
- Protocol assumption: at most one imem request is outstanding; imem_rsp_valid outside S_WAIT and S_DRAIN is ignored.
- Reset mid-operation: returns to the reset values immediately. Any in-flight imem response after release arrives in S_REQ and is ignored.

Optional Feature:
- Macro: FETCH_MISALIGN_EN.
- When defined:
  - A redirect with target[1:0]!=0 sets misalign_err=1 and does not load pc; state goes to S_DRAIN or S_REQ per the rules above.
  - misalign_err is sticky until the next trap_valid with an aligned target, or reset.
  - While misalign_err=1, imem_req_valid is forced 0.
- When undefined: misalign_err is constant 0 and targets load unchecked.

Test Plan:
- Reset, then ready=1, rsp one cycle later with data 32'h00000413, inst_ready=1 -> first imem_req_addr=32'h8000_0000; inst_valid with inst_pc=32'h8000_0000; next request at 32'h8000_0004.
- Hold inst_ready=0 for 5 cycles in S_OUT -> inst and inst_pc stable; no new imem_req_valid; pc stays 32'h8000_0000 until inst_ready.
- Redirect_valid with redirect_pc=32'h8000_0100 in S_WAIT, rsp two cycles later -> response discarded (inst_valid stays 0); next request addr=32'h8000_0100.
- Same-cycle trap_valid (trap_pc=32'h8000_0040) and redirect_valid (32'h8000_0200) -> next addr=32'h8000_0040.
- pc=32'hFFFF_FFFC, instruction consumed -> next request addr=32'h0000_0000.
- FETCH_MISALIGN_EN with redirect_pc=32'h8000_0102 -> misalign_err=1, imem_req_valid=0; then trap_pc=32'h8000_0040 -> misalign_err=0, fetch resumes at 32'h8000_0040.
